mem_rr_arbiter: RTL

Round-robin arbiter that shares one single-port synchronous RAM (1-cycle read latency) between NREQ requesters, with per-requester burst transfers and per-beat acknowledge. Sits between the fetch/load/store masters and the RAM instance of the instruction-fetcher example, replacing ad-hoc priority muxing with fair, burst-aware scheduling. The RAM is external; this block drives its enable, write-enable, address and data and returns its read data.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_rr_arbiter_if.sv | 36 +++
 rtl/rr_pick.sv | 32 +++
 rtl/mem_rr_arbiter.sv | 108 ++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the round-robin RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBurst,
    StDrain
  } arb_state_e;

  localparam int unsigned NREQ_DEF = 3;
  localparam int unsigned AW_DEF   = 8;
  localparam int unsigned DW_DEF   = 8;
  localparam int unsigned LW_DEF   = 3;

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// Requester-side and RAM-side bundle of the round-robin RAM arbiter.
interface mem_rr_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned LW   = LW_DEF
) ();

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_di;
  logic [NREQ*LW-1:0] req_len;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    beat_ack;
  logic [DW-1:0]      rd_data;
  logic               ram_en;
  logic               ram_we;
  logic [AW-1:0]      ram_addr;
  logic [DW-1:0]      ram_di;
  logic [DW-1:0]      ram_do;

  modport slave (
    input  req_valid, req_we, req_addr, req_di, req_len, ram_do,
    output req_ready, grant, beat_ack, rd_data, ram_en, ram_we, ram_addr, ram_di
  );

  modport master (
    output req_valid, req_we, req_addr, req_di, req_len, ram_do,
    input  req_ready, grant, beat_ack, rd_data, ram_en, ram_we, ram_addr, ram_di
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after i_last, wrapping.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_onehot,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_cand   = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      w_cand = IW'((int'(i_last) + k) % int'(NREQ));
      if (!o_any && i_req[w_cand]) begin
        o_any            = 1'b1;
        o_onehot[w_cand] = 1'b1;
        o_idx            = w_cand;
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Burst-aware round-robin arbiter sharing one synchronous single-port RAM.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned LW   = LW_DEF
) (
  input logic              clk,
  input logic              reset,
  mem_rr_arbiter_if.slave  bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      r_state, w_state_d;
  logic [IW-1:0]   r_last, r_idx, w_win_idx;
  logic [NREQ-1:0] r_grant, r_ready, r_ack, w_win;
  logic            w_any, w_last_beat, r_we;
  logic [AW-1:0]   r_addr;
  logic [LW-1:0]   r_len, r_cnt;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req    (bus.req_valid),
    .i_last   (r_last),
    .o_onehot (w_win),
    .o_idx    (w_win_idx),
    .o_any    (w_any)
  );

  assign w_last_beat = (r_cnt == r_len);

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_any) w_state_d = StBurst;
      StBurst: if (w_last_beat) w_state_d = StDrain;
      StDrain: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last  <= IW'(NREQ - 1);
      r_idx   <= '0;
      r_grant <= '0;
      r_ready <= '0;
      r_ack   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
    end else begin
      r_ready <= '0;
      // Acknowledge trails each issued beat by the RAM's one-cycle latency.
      r_ack   <= (r_state == StBurst) ? r_grant : '0;
      case (r_state)
        StIdle: begin
          if (w_any) begin
            r_grant <= w_win;
            r_ready <= w_win;
            r_idx   <= w_win_idx;
            r_last  <= w_win_idx;
            r_addr  <= bus.req_addr[w_win_idx*AW +: AW];
            r_len   <= bus.req_len[w_win_idx*LW +: LW];
            r_we    <= bus.req_we[w_win_idx];
            r_cnt   <= '0;
          end
        end
        StBurst: begin
          r_addr <= r_addr + AW'(1);
          r_cnt  <= r_cnt + LW'(1);
        end
        StDrain: r_grant <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.ram_en   = 1'b0;
    bus.ram_we   = 1'b0;
    bus.ram_addr = '0;
    bus.ram_di   = '0;
    if (r_state == StBurst) begin
      bus.ram_en   = 1'b1;
      bus.ram_we   = r_we;
      bus.ram_addr = r_addr;
      bus.ram_di   = bus.req_di[r_idx*DW +: DW];
    end
  end

  assign bus.grant     = r_grant;
  assign bus.req_ready = r_ready;
  assign bus.beat_ack  = r_ack;
  assign bus.rd_data   = bus.ram_do;

endmodule
